// File: rtl/csa_result_accumulator.sv
// Accumulates 5-bit {cout,sum} results from a carry-select adder into frames of
// N_SAMPLES values, presenting each frame total with a sticky overflow flag.
module csa_result_accumulator #(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic [3:0]       sum_in,
    input  logic             cout_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [3:0]       count,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       state_dbg
);

    // Handshakes: a sample transfers on an edge with in_valid && in_ready; a frame
    // transfers on an edge with out_valid && out_ready. in_ready never looks at in_valid.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [3:0] LAST_COUNT = 4'(N_SAMPLES);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         count_q, count_d;
    logic               overflow_q, overflow_d;

    logic               accept;
    logic               release_frame;
    logic [ACC_W:0]     sum_ext;
    logic [3:0]         count_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        accept        = (state_q == ST_ACCUM) && ena && in_valid;
        release_frame = (state_q == ST_HOLD) && out_ready;
        // Extra top bit captures the carry out of the accumulator MSB.
        sum_ext       = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, cout_in, sum_in};
        count_inc     = count_q + 4'd1;

        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (clear) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ena) state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d      = sum_ext[ACC_W-1:0];
                        count_d    = count_inc;
                        overflow_d = overflow_q | sum_ext[ACC_W];
                        if (count_inc == LAST_COUNT) state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (release_frame) begin
                        acc_d      = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        state_d    = ena ? ST_ACCUM : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_ACCUM) && ena;
        out_valid = (state_q == ST_HOLD);
        acc_out   = acc_q;
        count     = count_q;
        overflow  = overflow_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_csa_result_accumulator.sv
// Directed bench for csa_result_accumulator: a default-parameter instance and an
// ACC_W=6 / N_SAMPLES=3 instance for the overflow case.
module tb_csa_result_accumulator;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       ena, clear, cout_in, in_valid, out_ready;
    logic [3:0] sum_in;
    logic       in_ready, overflow, out_valid;
    logic [7:0] acc_out;
    logic [3:0] count;
    logic [1:0] state_dbg;

    logic       ena6, clear6, cout6, in_valid6, out_ready6;
    logic [3:0] sum6;
    logic       in_ready6, overflow6, out_valid6;
    logic [5:0] acc6;
    logic [3:0] count6;
    logic [1:0] state6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_result_accumulator #(.ACC_W(8), .N_SAMPLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .sum_in(sum_in), .cout_in(cout_in), .in_valid(in_valid),
        .in_ready(in_ready), .acc_out(acc_out), .count(count),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
        .state_dbg(state_dbg)
    );

    csa_result_accumulator #(.ACC_W(6), .N_SAMPLES(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .ena(ena6), .clear(clear6),
        .sum_in(sum6), .cout_in(cout6), .in_valid(in_valid6),
        .in_ready(in_ready6), .acc_out(acc6), .count(count6),
        .overflow(overflow6), .out_valid(out_valid6), .out_ready(out_ready6),
        .state_dbg(state6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [7:0] e_acc, input logic [3:0] e_cnt,
                            input logic e_ovf, input logic e_ov, input logic e_ir);
        chk({tag, ".acc"}, 32'(acc_out), 32'(e_acc));
        chk({tag, ".count"}, 32'(count), 32'(e_cnt));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_ir));
        chk({tag, ".excl"}, 32'(out_valid & in_ready), 32'd0);
    endtask

    task automatic sample(input logic [4:0] v);
        cout_in = v[4];
        sum_in  = v[3:0];
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; clear = 1'b0; sum_in = 4'd0; cout_in = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        ena6 = 1'b0; clear6 = 1'b0; sum6 = 4'd0; cout6 = 1'b0; in_valid6 = 1'b0; out_ready6 = 1'b0;

        #3;
        chk_main("reset", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.state", 32'(state_dbg), 32'(S_IDLE));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_main("idle_no_ena", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Four back-to-back accepts of 31.
        ena = 1'b1;
        tick();
        chk("accum_entry.state", 32'(state_dbg), 32'(S_ACCUM));
        chk("accum_entry.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        sample(5'h1F);
        tick();
        tick();
        chk_main("b2b_mid", 8'd62, 4'd2, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk_main("b2b_hold", 8'h7C, 4'd4, 1'b0, 1'b1, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_main("b2b_release", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("b2b_release.state", 32'(state_dbg), 32'(S_ACCUM));
        out_ready = 1'b0;

        // HOLD stall with in_valid asserted.
        in_valid = 1'b1;
        sample(5'd2);
        repeat (4) tick();
        sample(5'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_main("hold_stall", 8'd8, 4'd4, 1'b0, 1'b1, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_main("stall_release", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sample(5'd3);
        tick();
        chk_main("next_frame", 8'd3, 4'd1, 1'b0, 1'b0, 1'b1);

        // Clear on the same edge as an accept.
        clear = 1'b1;
        sample(5'd4);
        tick();
        chk_main("clear_vs_accept", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("clear_vs_accept.state", 32'(state_dbg), 32'(S_IDLE));
        clear    = 1'b0;
        in_valid = 1'b0;
        tick();

        // Pause with ena low mid-frame.
        in_valid = 1'b1;
        sample(5'd3);
        tick();
        sample(5'd5);
        tick();
        chk_main("pause_pre", 8'd8, 4'd2, 1'b0, 1'b0, 1'b1);
        ena = 1'b0;
        sample(5'd9);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_main("pause", 8'd8, 4'd2, 1'b0, 1'b0, 1'b0);
            chk("pause.state", 32'(state_dbg), 32'(S_ACCUM));
        end
        ena = 1'b1;
        sample(5'd1);
        tick();
        tick();
        chk_main("pause_done", 8'd10, 4'd4, 1'b0, 1'b1, 1'b0);
        in_valid  = 1'b0;
        ena       = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_main("release_idle", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("release_idle.state", 32'(state_dbg), 32'(S_IDLE));

        // Clear beats a simultaneous release.
        ena       = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b1;
        sample(5'd6);
        repeat (4) tick();
        chk_main("pre_clear_hold", 8'd24, 4'd4, 1'b0, 1'b1, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear     = 1'b1;
        tick();
        chk("clear_vs_release.state", 32'(state_dbg), 32'(S_IDLE));
        chk_main("clear_vs_release", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clear     = 1'b0;
        out_ready = 1'b0;
        tick();

        // Asynchronous reset mid-frame.
        in_valid = 1'b1;
        sample(5'd9);
        tick();
        chk_main("pre_async", 8'd9, 4'd1, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("async_rst", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("async_rst.state", 32'(state_dbg), 32'(S_IDLE));
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst.state", 32'(state_dbg), 32'(S_ACCUM));
        in_valid = 1'b1;
        sample(5'd4);
        tick();
        chk_main("post_rst_frame", 8'd4, 4'd1, 1'b0, 1'b0, 1'b1);

        // Back-to-back frames with out_ready held high.
        out_ready = 1'b1;
        sample(5'd1);
        repeat (3) tick();
        chk_main("hi_ready_hold", 8'd7, 4'd4, 1'b0, 1'b1, 1'b0);
        tick();
        chk_main("hi_ready_rel", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        chk_main("hi_ready_hold2", 8'd4, 4'd4, 1'b0, 1'b1, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // ACC_W=6 overflow.
        ena6 = 1'b1;
        tick();
        in_valid6 = 1'b1;
        cout6     = 1'b1;
        sum6      = 4'hF;
        tick();
        chk("w6_1.acc", 32'(acc6), 32'd31);
        chk("w6_1.ovf", 32'(overflow6), 32'd0);
        tick();
        chk("w6_2.acc", 32'(acc6), 32'd62);
        chk("w6_2.ovf", 32'(overflow6), 32'd0);
        tick();
        chk("w6_3.acc", 32'(acc6), 32'd29);
        chk("w6_3.ovf", 32'(overflow6), 32'd1);
        chk("w6_3.out_valid", 32'(out_valid6), 32'd1);
        chk("w6_3.count", 32'(count6), 32'd3);
        tick();
        chk("w6_hold.acc", 32'(acc6), 32'd29);
        chk("w6_hold.ovf", 32'(overflow6), 32'd1);
        chk("w6_hold.in_ready", 32'(in_ready6), 32'd0);
        in_valid6  = 1'b0;
        out_ready6 = 1'b1;
        tick();
        chk("w6_rel.acc", 32'(acc6), 32'd0);
        chk("w6_rel.ovf", 32'(overflow6), 32'd0);
        chk("w6_rel.out_valid", 32'(out_valid6), 32'd0);
        chk("w6_rel.state", 32'(state6), 32'(S_ACCUM));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_result_accumulator.md
CSA_RESULT_ACCUMULATOR -- requirements
Module: csa_result_accumulator

Interface
REQ-001 Parameter ACC_W, default 8, accumulator width in bits, legal range 5..16.
REQ-002 Parameter N_SAMPLES, default 4, adder results summed per output frame, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ena  input  1  design-enable; high = block may accept input.
REQ-006 clear  input  1  synchronous frame abort; returns the block to its empty state.
REQ-007 sum_in  input  4  sum output of the upstream carry-select adder.
REQ-008 cout_in  input  1  carry output of the upstream carry-select adder.
REQ-009 in_valid  input  1  sum_in/cout_in valid this cycle.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 acc_out  output  ACC_W  running or final accumulated total.
REQ-012 count  output  4  samples accepted in the current frame.
REQ-013 overflow  output  1  sticky; the frame total exceeded 2^ACC_W-1.
REQ-014 out_valid  output  1  frame complete; acc_out/overflow final.
REQ-015 out_ready  input  1  consumer takes the frame.

Function
REQ-016 Each sample's value is the 5-bit zero-extended value {cout_in,sum_in}, range 0..31.
REQ-017 FSM states: IDLE, ACCUM, HOLD.
REQ-018 IDLE: in_ready=0; ena=1 moves the FSM to ACCUM on the next edge.
REQ-019 ACCUM: in_ready=ena.
REQ-020 ACCUM accept: a sample is accepted on an edge where in_valid=1 and in_ready=1.
REQ-021 ACCUM update: on accept, acc_out <= acc_out + sample mod 2^ACC_W and count <= count+1.
REQ-022 ACCUM pause: ena=0 in ACCUM holds all state; the FSM does not leave ACCUM.
REQ-023 Overflow: a carry out of bit ACC_W-1 during any add sets overflow; it stays set until frame release, clear or reset.
REQ-024 Frame end: the accept that brings count to N_SAMPLES moves the FSM to HOLD on that same edge.
REQ-025 Frame latency: out_valid=1 in the cycle after the final accept, with acc_out holding the full total.
REQ-026 HOLD: out_valid=1 and in_ready=0; acc_out, count and overflow are frozen.
REQ-027 HOLD: in_valid is ignored and no sample is dropped into the next frame.
REQ-028 Release: on an edge where out_valid=1 and out_ready=1, acc_out, count and overflow clear to 0.
REQ-029 Release target: after release the FSM moves to ACCUM if ena=1, else to IDLE.
REQ-030 Release back-to-back: out_ready may be held high; the minimum frame spacing is N_SAMPLES+1 cycles.
REQ-031 clear=1, any state: the next edge zeroes acc_out, count and overflow and sets the FSM to IDLE.
REQ-032 clear priority: clear overrides a simultaneous accept or release.
REQ-033 out_valid and in_ready are never both 1 in the same cycle.
REQ-034 in_ready depends only on state and ena, never on in_valid.

Reset
REQ-035 While rst_n=0, regardless of clk: FSM=IDLE, acc_out=0, count=0, overflow=0, out_valid=0, in_ready=0.
REQ-036 Reset asserted mid-frame or in HOLD discards the partial or final frame; the first accept after reset starts a new frame at count=0.
REQ-037 Release from reset is synchronised to clk by the integration; the block's state after rst_n deassert follows REQ-018.

Verification
REQ-038 Defaults, ena=1, four accepts of {1,F} back-to-back -> next cycle out_valid=1, acc_out=0x7C, count=4, overflow=0.
REQ-039 ACC_W=6, three accepts of {1,F} -> acc_out=29 (93 mod 64), overflow=1 and stays 1 through HOLD; release -> acc_out=0, overflow=0.
REQ-040 Frame reaches HOLD, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, acc_out/count unchanged; out_ready=1 -> release, in_ready=1 next cycle, next frame starts at count=0.
REQ-041 Two accepts (values 3, 5), then ena=0 for 2 cycles with in_valid=1 -> acc_out=8, count=2 held; ena=1, two more accepts of 1 -> out_valid=1, acc_out=10.
REQ-042 Mid-frame, clear=1 asserted on the same edge as an accept -> acc_out=0, count=0, FSM IDLE; clear has priority over the accept.
REQ-043 Mid-frame, rst_n pulsed low between clock edges -> outputs zero immediately, before the next clk edge.
